// File: rtl/reset_pkg.sv
// Shared types for the staged reset controller: reset cause codes and sequencer states.
package reset_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SW   = 2'd1,
    CAUSE_WDOG = 2'd2
  } rst_cause_t;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_t;

endpackage

// File: rtl/wdog_timer.sv
// Watchdog counter: counts enabled, unkicked cycles; expire is a same-cycle terminal-count flag.
// Counter restarts on clr, disable, kick or expiry.
module wdog_timer #(
  parameter int WDOG_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = en && !kick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || kick || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all stage resets for HOLD_CYCLES, then releases one stage every
// STAGE_GAP cycles; software request or watchdog expiry restarts the sequence one edge later.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int NUM_STAGES  = 3,
  parameter int WDOG_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst_req,
  input  logic                  wdog_en,
  input  logic                  wdog_kick,
  output logic [NUM_STAGES-1:0] rst_stage_n,
  output logic                  rst_busy,
  output logic [1:0]            rst_cause
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] STG_LAST  = IW'(NUM_STAGES - 1);

  rst_state_t            state_q, state_d;
  rst_cause_t            cause_q, cause_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]         stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] stage_n_q, stage_n_d;
  logic                  busy_q, busy_d;
  logic                  wdog_expire;
  logic                  rst_event;

  wdog_timer #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_RUN),
    .en    (wdog_en),
    .kick  (wdog_kick),
    .expire(wdog_expire)
  );

  // Software request outranks watchdog expiry, which only counts in RUN.
  assign rst_event = sw_rst_req || ((state_q == ST_RUN) && wdog_expire);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    stage_n_d   = stage_n_q;
    busy_d      = busy_q;

    if (rst_event) begin
      state_d     = ST_HOLD;
      cause_d     = sw_rst_req ? CAUSE_SW : CAUSE_WDOG;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      stage_idx_d = '0;
      stage_n_d   = '0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            stage_n_d[0] = 1'b1;
            gap_cnt_d    = '0;
            stage_idx_d  = IW'(1);
            if (NUM_STAGES == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            stage_n_d[stage_idx_q] = 1'b1;
            gap_cnt_d              = '0;
            if (stage_idx_q == STG_LAST) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              stage_idx_d = stage_idx_q + 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      cause_q     <= CAUSE_POR;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      stage_n_q   <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      stage_n_q   <= stage_n_d;
      busy_q      <= busy_d;
    end
  end

  assign rst_stage_n = stage_n_q;
  assign rst_busy    = busy_q;
  assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table of timing scenarios plus random traffic
// against a reference model that tracks only the last reset edge, cause and watchdog run length.
module tb_reset_sequencer;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int NST   = 3;
  localparam int WDOG  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sw_rst_req = 1'b0;
  logic           wdog_en = 1'b0;
  logic           wdog_kick = 1'b0;
  logic [NST-1:0] rst_stage_n;
  logic           rst_busy;
  logic [1:0]     rst_cause;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP),
    .NUM_STAGES (NST),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .wdog_en    (wdog_en),
    .wdog_kick  (wdog_kick),
    .rst_stage_n(rst_stage_n),
    .rst_busy   (rst_busy),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: absolute edge count, edge of last reset, its cause, watchdog run length.
  longint k       = 0;
  longint last_e  = 0;
  int     m_cause = 0;
  int     m_wd    = 0;

  typedef struct {
    int         edge_no;
    logic       r;
    logic       s;
    logic       w;
    logic       kk;
    logic [5:0] exp_out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int e, logic r, logic s, logic w, logic kk,
                              logic [2:0] st, logic b, logic [1:0] c);
    vec_t v;
    v.edge_no = e; v.r = r; v.s = s; v.w = w; v.kk = kk;
    v.exp_out = {st, b, c};
    return v;
  endfunction

  function automatic logic [5:0] dut_out();
    return {rst_stage_n, rst_busy, rst_cause};
  endfunction

  function automatic logic [5:0] model_out();
    logic [2:0] st;
    for (int i = 0; i < NST; i++)
      st[i] = (k >= last_e + HOLD + i * GAP);
    return {st, ~&st, 2'(m_cause)};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s edge %0d: got stages/busy/cause %b required %b", name, k, act, exp_v);
  endtask

  task automatic step(input logic r, input logic s, input logic w, input logic kk);
    logic in_run;
    rst_n = r; sw_rst_req = s; wdog_en = w; wdog_kick = kk;
    @(posedge clk);
    in_run = (k > last_e + HOLD + (NST - 1) * GAP);
    if (!r) begin
      last_e = k; m_cause = 0; m_wd = 0;
    end else if (s) begin
      last_e = k; m_cause = 1; m_wd = 0;
    end else if (in_run && w && !kk) begin
      m_wd++;
      if (m_wd == WDOG) begin
        last_e = k; m_cause = 2; m_wd = 0;
      end
    end else begin
      m_wd = 0;
    end
    @(negedge clk);
    chk("model", dut_out(), model_out());
  endtask

  initial begin
    longint base = 0;
    logic   en_s = 1'b0;

    // POR then software reset in RUN
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(3,  1,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(4,  1,0,0,0, 3'b001,1,0));
    tbl.push_back(mk(5,  1,0,0,0, 3'b001,1,0));
    tbl.push_back(mk(6,  1,0,0,0, 3'b011,1,0));
    tbl.push_back(mk(7,  1,0,0,0, 3'b011,1,0));
    tbl.push_back(mk(8,  1,0,0,0, 3'b111,0,0));
    tbl.push_back(mk(20, 1,1,0,0, 3'b000,1,1));
    tbl.push_back(mk(23, 1,0,0,0, 3'b000,1,1));
    tbl.push_back(mk(24, 1,0,0,0, 3'b001,1,1));
    tbl.push_back(mk(26, 1,0,0,0, 3'b011,1,1));
    tbl.push_back(mk(27, 1,0,0,0, 3'b011,1,1));
    tbl.push_back(mk(28, 1,0,0,0, 3'b111,0,1));
    // mid-sequence restart
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(4,  1,0,0,0, 3'b001,1,0));
    tbl.push_back(mk(5,  1,1,0,0, 3'b000,1,1));
    tbl.push_back(mk(8,  1,0,0,0, 3'b000,1,1));
    tbl.push_back(mk(9,  1,0,0,0, 3'b001,1,1));
    tbl.push_back(mk(11, 1,0,0,0, 3'b011,1,1));
    tbl.push_back(mk(12, 1,0,0,0, 3'b011,1,1));
    tbl.push_back(mk(13, 1,0,0,0, 3'b111,0,1));
    // watchdog expiry without kicks
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(9,  1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(15, 1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(16, 1,0,1,0, 3'b000,1,2));
    // kick at 15 postpones expiry to 23
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(9,  1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(15, 1,0,1,1, 3'b111,0,0));
    tbl.push_back(mk(16, 1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(22, 1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(23, 1,0,1,0, 3'b000,1,2));
    // software request on the expiry edge wins
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(9,  1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(16, 1,1,1,0, 3'b000,1,1));
    // kick on the expiry edge suppresses it
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(9,  1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(16, 1,0,1,1, 3'b111,0,0));
    tbl.push_back(mk(23, 1,0,1,0, 3'b111,0,0));
    tbl.push_back(mk(24, 1,0,1,0, 3'b000,1,2));
    // watchdog disabled for 100 cycles
    tbl.push_back(mk(0,  0,0,0,0, 3'b000,1,0));
    tbl.push_back(mk(108,1,0,0,0, 3'b111,0,0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].r) base = k;
      while (k < base + tbl[i].edge_no) begin
        step(1'b1, 1'b0, en_s, 1'b0);
        k++;
      end
      step(tbl[i].r, tbl[i].s, tbl[i].w, tbl[i].kk);
      en_s = tbl[i].w;
      chk("vec", dut_out(), tbl[i].exp_out);
      k++;
    end

    // sw_rst_req held high keeps everything asserted
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("sw_held", dut_out(), 6'b000_1_01);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) en_s = ~en_s;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 149) == 0),
           en_s,
           ($urandom_range(0, 11) == 0));
      k++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller for the segway control core. It sits directly behind the reset synchronizer: it consumes the already-synchronized system reset and adds two more reset sources, a software reset request and a watchdog timeout. It drives an ordered set of per-subsystem active-low resets, releasing them one at a time after a minimum hold period, and records the cause of the last reset.

## Interface
- `HOLD_CYCLES`, 16: minimum number of cycles all stage resets stay asserted after any reset event (≥1).
- `STAGE_GAP`, 8: cycles between successive stage releases (≥1).
- `NUM_STAGES`, 3: number of reset stages; stage 0 is released first (≥1).
- `WDOG_CYCLES`, 50000: consecutive unkicked enabled cycles that trigger a watchdog reset (≥2).

- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sw_rst_req` in 1: software reset request, sampled every cycle.
- `wdog_en` in 1: watchdog enable.
- `wdog_kick` in 1: watchdog service pulse.
- `rst_stage_n` out `NUM_STAGES`: per-stage active-low resets, registered.
- `rst_busy` out 1: high while any stage is asserted, registered.
- `rst_cause` out 2: cause of the last reset. 0 = POR, 1 = software, 2 = watchdog, 3 = unused. Registered.

## Operation
- FSM states: HOLD, RELEASE, RUN.
- Reset (`rst_n` low at an edge):
  - state HOLD; `rst_stage_n`=all 0; `rst_busy`=1; `rst_cause`=POR.
  - Hold counter, stage index and watchdog counter all cleared to 0.
- HOLD: the hold counter increments each cycle. At the edge where the counter equals `HOLD_CYCLES-1`:
  - `rst_stage_n[0]` goes to 1;
  - go to RELEASE (or RUN if `NUM_STAGES`=1);
  - the gap counter is cleared.
- RELEASE: the gap counter increments. At the edge where it equals `STAGE_GAP-1`:
  - release the next stage and clear the gap counter;
  - releasing stage `NUM_STAGES-1` moves to RUN and drops `rst_busy` on the same edge.
- RUN:
  - Watchdog counter behaviour:
    - `wdog_en` low: counter held at 0;
    - kick: counter cleared;
    - otherwise: counter increments.
  - Expiry occurs when the counter equals `WDOG_CYCLES-1`, `wdog_en` is high and there is no kick.
- Reset events are `sw_rst_req` high (any state) or watchdog expiry (RUN only). On the edge sampling the event:
  - all stages go to 0 and `rst_busy` goes to 1;
  - state HOLD; all counters cleared;
  - `rst_cause` updated.
- Priority rules:
  - `rst_n` over everything.
  - `sw_rst_req` over watchdog expiry: cause = software.
  - `wdog_kick` over expiry in the same cycle: no reset.
- `sw_rst_req` during HOLD or RELEASE restarts the full sequence. Stages already released are reasserted.
- `sw_rst_req` held high keeps the block in HOLD with the counter at 0.
- `rst_cause` changes only on a reset event. It persists through RUN.
- Counter widths: `$clog2(max+1)` of the respective terminal count. No wrap-around is reachable.

## Timing
- Let e be the last edge at which `rst_n` was sampled low or a reset event was sampled.
  - Stage i rises at edge e + `HOLD_CYCLES` + i·`STAGE_GAP`.
  - `rst_busy` falls with the last stage.
- Request-to-assert latency is 1 edge. The request is sampled at edge e, and the outputs are low in the cycle after edge e.
- The watchdog fires on the `WDOG_CYCLES`-th consecutive enabled, unkicked edge in RUN.
- All outputs come straight from flops; there is no combinational path from any input to any output.

## Structure
- Shared package `reset_pkg`:
  - `rst_cause_t` enum: POR, SW, WDOG;
  - `rst_state_t` enum: HOLD, RELEASE, RUN.
- One natural sub-module, `wdog_timer`:
  - inputs: clk, rst_n, clr, en, kick;
  - output: `expire`, a combinational terminal-count flag;
  - parameter: `WDOG_CYCLES`.
  - The parent drives `clr` high whenever the state is not RUN.

## Test plan
All scenarios use `HOLD_CYCLES`=4, `STAGE_GAP`=2, `NUM_STAGES`=3, `WDOG_CYCLES`=8.
- POR: `rst_n` low at edge 0, high afterwards.
  - `rst_stage_n` reads 000 until edge 4, then 001 at edge 4, 011 at edge 6, 111 at edge 8.
  - `rst_busy` falls at edge 8; `rst_cause`=0.
- Software reset in RUN: `sw_rst_req` pulse sampled at edge 20.
  - Stages read 000 after edge 20, then release at edges 24, 26, 28.
  - `rst_cause`=1.
- Mid-sequence restart: `sw_rst_req` at edge 5 of the POR sequence.
  - Stage 0 drops back to 0 at edge 5.
  - Releases follow at edges 9, 11, 13.
- Watchdog:
  - `wdog_en`=1 in RUN with no kicks from edge 9: expiry at edge 16, stages 000, `rst_cause`=2.
  - Same run with a kick at edge 15: no reset until edge 23.
- Simultaneous: `sw_rst_req` on the expiry edge gives `rst_cause`=1.
- Kick on the expiry edge: no reset.
- `wdog_en`=0 for 100 cycles: no reset.
